// File: rtl/axi_hp_resp_pkg.sv
// Shared types and helpers for the AXI3 HP write responder.
// Queue entries carry the burst ID and either the burst length or the response code.
package axi_hp_resp_pkg;

  localparam int AXI_ID_W = 6;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [3:0]          len;
  } aw_entry_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } b_entry_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n += {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sync_fifo_ff.sv
// Register-based synchronous FIFO with a zero-latency head and
// look-ahead full/empty flags (state after this cycle's push/pop).
module sync_fifo_ff #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             full_next,
  output logic             empty_next
);

  localparam int               PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  assign full_next  = (count_next == FULL_COUNT);
  assign empty_next = (count_next == '0);

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // NOTE: storage is left unreset; pointers and count alone decide which slots hold valid data.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/axi_hp_wr_responder.sv
// AXI3 write-channel responder for the HP port: framing check, B responses,
// pattern-driven backpressure and traffic counters.
module axi_hp_wr_responder
  import axi_hp_resp_pkg::*;
#(
  parameter int ID_W     = AXI_ID_W,
  parameter int DATA_W   = 64,
  parameter int AW_DEPTH = 4,
  parameter int B_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     awid,
  input  logic [3:0]          awlen,
  input  logic                wvalid,
  output logic                wready,
  input  logic [ID_W-1:0]     wid,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  input  logic [7:0]          aw_pattern,
  input  logic [7:0]          w_pattern,
  input  logic                clr,
  output logic [31:0]         burst_cnt,
  output logic [31:0]         beat_cnt,
  output logic [31:0]         byte_cnt,
  output logic [15:0]         err_cnt
);

  localparam int STRB_W = DATA_W / 8;

  logic [2:0]  ph;
  logic [2:0]  ph_next;
  aw_entry_t   aw_push_entry;
  aw_entry_t   aw_head;
  b_entry_t    b_push_entry;
  b_entry_t    b_head;
  logic        aw_push;
  logic        aw_full_next;
  logic        aw_empty_next;
  logic        b_push;
  logic        b_pop;
  logic        b_empty;
  logic        b_full_next;
  logic        w_beat;
  logic        at_len;
  logic        beat_err;
  logic        burst_err;
  logic        burst_end;
  logic [3:0]  bi;
  logic        err_acc;
  logic [31:0] strb_ones;
  logic        unused_aw_full;
  logic        unused_aw_empty;
  logic        unused_b_full;
  logic        unused_b_empty_next;
  logic        unused_wdata;

  assign unused_wdata = ^wdata;
  assign ph_next      = ph + 3'd1;

  assign aw_push       = awvalid & awready;
  assign aw_push_entry = '{id: AXI_ID_W'(awid), len: awlen};

  assign w_beat    = wvalid & wready;
  assign at_len    = (bi == aw_head.len);
  // A mismatch between wlast and the length-derived last beat covers both early and missing last.
  assign beat_err  = (AXI_ID_W'(wid) != aw_head.id) | (wlast ^ at_len);
  assign burst_end = w_beat & (wlast | at_len);
  assign burst_err = err_acc | beat_err;

  assign b_push       = burst_end;
  assign b_push_entry = '{id: aw_head.id, resp: burst_err ? RESP_SLVERR : RESP_OKAY};
  assign b_pop        = bvalid & bready;

  sync_fifo_ff #(
    .WIDTH ($bits(aw_entry_t)),
    .DEPTH (AW_DEPTH)
  ) u_aw_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (aw_push),
    .push_data  (aw_push_entry),
    .pop        (burst_end),
    .head       (aw_head),
    .full       (unused_aw_full),
    .empty      (unused_aw_empty),
    .full_next  (aw_full_next),
    .empty_next (aw_empty_next)
  );

  sync_fifo_ff #(
    .WIDTH ($bits(b_entry_t)),
    .DEPTH (B_DEPTH)
  ) u_b_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (b_push),
    .push_data  (b_push_entry),
    .pop        (b_pop),
    .head       (b_head),
    .full       (unused_b_full),
    .empty      (b_empty),
    .full_next  (b_full_next),
    .empty_next (unused_b_empty_next)
  );

  assign bvalid = ~b_empty;
  assign bid    = b_empty ? '0 : ID_W'(b_head.id);
  assign bresp  = b_empty ? RESP_OKAY : b_head.resp;

  // Readies are registered from next-cycle queue state, so W waits at least one cycle after AW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph      <= '0;
      awready <= 1'b0;
      wready  <= 1'b0;
    end else begin
      ph      <= ph_next;
      awready <= ~aw_full_next & aw_pattern[ph_next];
      wready  <= ~aw_empty_next & ~b_full_next & w_pattern[ph_next];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bi      <= '0;
      err_acc <= 1'b0;
    end else if (w_beat) begin
      if (burst_end) begin
        bi      <= '0;
        err_acc <= 1'b0;
      end else begin
        bi      <= bi + 4'd1;
        err_acc <= burst_err;
      end
    end
  end

  always_comb begin
    strb_ones = '0;
    for (int i = 0; i < STRB_W / 8; i++) begin
      strb_ones += 32'(popcount8(wstrb[i*8 +: 8]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= '0;
      beat_cnt  <= '0;
      byte_cnt  <= '0;
      err_cnt   <= '0;
    end else if (clr) begin
      burst_cnt <= '0;
      beat_cnt  <= '0;
      byte_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      if (w_beat) begin
        beat_cnt <= beat_cnt + 32'd1;
        byte_cnt <= byte_cnt + strb_ones;
      end
      if (burst_end) begin
        burst_cnt <= burst_cnt + 32'd1;
        if (burst_err) err_cnt <= err_cnt + 16'd1;
      end
    end
  end

endmodule
